// File: rtl/irq_timer_if.sv
// Bridge-side register bus and interrupt line of irq_timer.
interface irq_timer_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/irq_timer.sv
// Programmable down-counting interrupt timer with one-shot and auto-reload modes.
// Optional 8-bit prescaler at offset 3 when IRQ_TIMER_PRESCALE_EN is defined.
module irq_timer (
    input  logic       clk,
    input  logic       reset,
    irq_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        flag, flag_nxt;
    logic        en_clr;
    logic        step;
    logic [1:0]  sel;
    logic        wr_ctrl, wr_preset;
    logic        unused_addr;

    assign sel         = bus.Addr[3:2];
    assign wr_ctrl     = bus.WE && (sel == 2'd0);
    assign wr_preset   = bus.WE && (sel == 2'd1);
    assign unused_addr = ^bus.Addr[31:4];

`ifdef IRQ_TIMER_PRESCALE_EN
    logic [7:0] psc, psc_cnt, psc_cnt_nxt;
    logic       wr_psc;

    assign wr_psc = bus.WE && (sel == 2'd3);
    // >= keeps the tick alive if PSC is lowered below the running prescale count
    assign step   = (psc_cnt >= psc);

    always_comb begin
        psc_cnt_nxt = psc_cnt;
        if (state == LOAD)
            psc_cnt_nxt = 8'd0;
        else if (state == CNT && ctrl[0])
            psc_cnt_nxt = step ? 8'd0 : psc_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc     <= 8'd0;
            psc_cnt <= 8'd0;
        end else begin
            psc_cnt <= psc_cnt_nxt;
            if (wr_psc)
                psc <= bus.Din[7:0];
        end
    end
`else
    assign step = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flag_nxt  = flag;
        en_clr    = 1'b0;
        case (state)
            IDLE: if (ctrl[0]) state_nxt = LOAD;
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!ctrl[0])
                    state_nxt = IDLE;
                else if (step) begin
                    if (count != 32'd0)
                        count_nxt = count - 32'd1;
                    else begin
                        flag_nxt  = 1'b1;
                        state_nxt = INT;
                    end
                end
            end
            INT: begin
                // MODE 1x behaves as one-shot
                if (ctrl[2:1] == 2'b01) begin
                    flag_nxt  = 1'b0;
                    state_nxt = LOAD;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
        if (wr_ctrl)
            flag_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ctrl   <= 4'd0;
            preset <= 32'd0;
            count  <= 32'd0;
            flag   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            flag  <= flag_nxt;
            // a bus write to CTRL overrides the one-shot EN clear
            if (wr_ctrl)
                ctrl <= bus.Din[3:0];
            else if (en_clr)
                ctrl[0] <= 1'b0;
            if (wr_preset)
                preset <= bus.Din;
        end
    end

    always_comb begin
        bus.Dout = 32'd0;
        case (sel)
            2'd0: bus.Dout = {28'd0, ctrl};
            2'd1: bus.Dout = preset;
            2'd2: bus.Dout = count;
`ifdef IRQ_TIMER_PRESCALE_EN
            2'd3: bus.Dout = {24'd0, psc};
`else
            2'd3: bus.Dout = 32'd0;
`endif
        endcase
    end

    assign bus.IRQ = flag & ctrl[3];
endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer: register-map vector table plus timing sequences.
module tb_irq_timer;
    logic clk;
    logic reset;
    irq_timer_if bus ();

    irq_timer dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [1:0]  off;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [0:14];
    int          n_cmp;
    int          n_fail;
    int          n;
    logic [31:0] d;
    logic        irq_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] data);
        bus.Addr = {28'd0, off};
        #1;
        data = bus.Dout;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        bus.Addr = {28'd0, off};
        bus.Din  = data;
        bus.WE   = 1'b1;
        @(negedge clk);
        bus.WE   = 1'b0;
        bus.Addr = 30'd2;
    endtask

    task automatic wait_irq(output int cycles);
        cycles = 0;
        while (bus.IRQ !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_reset;
        reset  = 1'b0;
        bus.WE = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle_watch(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.IRQ !== 1'b0) irq_seen = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        bus.WE   = 1'b0;
        bus.Addr = 30'd0;
        bus.Din  = 32'd0;
        n_cmp    = 0;
        n_fail   = 0;

        // {we, offset, write data, expected read}
        vecs[0]  = '{1'b0, 2'd0, 32'd0, 32'd0};
        vecs[1]  = '{1'b0, 2'd1, 32'd0, 32'd0};
        vecs[2]  = '{1'b0, 2'd2, 32'd0, 32'd0};
        vecs[3]  = '{1'b0, 2'd3, 32'd0, 32'd0};
        vecs[4]  = '{1'b1, 2'd1, 32'hDEADBEEF, 32'd0};
        vecs[5]  = '{1'b0, 2'd1, 32'd0, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 2'd0, 32'hFFFFFFF6, 32'd0};
        vecs[7]  = '{1'b0, 2'd0, 32'd0, 32'h00000006};
        vecs[8]  = '{1'b1, 2'd2, 32'h00001234, 32'd0};
        vecs[9]  = '{1'b0, 2'd2, 32'd0, 32'd0};
        vecs[10] = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'd0};
`ifdef IRQ_TIMER_PRESCALE_EN
        vecs[11] = '{1'b0, 2'd3, 32'd0, 32'h000000FF};
`else
        vecs[11] = '{1'b0, 2'd3, 32'd0, 32'd0};
`endif
        vecs[12] = '{1'b1, 2'd0, 32'd0, 32'd0};
        vecs[13] = '{1'b1, 2'd1, 32'h0000005A, 32'd0};
        vecs[14] = '{1'b0, 2'd1, 32'd0, 32'h0000005A};

        @(negedge clk);
        do_reset;
        chk("reset_irq", {31'd0, bus.IRQ}, 32'd0);
        for (int i = 0; i <= 14; i++) begin
            if (vecs[i].we)
                wr(vecs[i].off, vecs[i].din);
            else begin
                rd(vecs[i].off, d);
                chk($sformatf("regvec[%0d]", i), d, vecs[i].exp);
            end
        end
        chk("regvec_irq", {31'd0, bus.IRQ}, 32'd0);

        // one-shot, PRESET=5
        do_reset;
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        n = 0;
        while (bus.IRQ !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 4) begin
                rd(2'd2, d);
                chk("oneshot_count_mid", d, 32'd3);
            end
        end
        chk("oneshot_latency", n, 32'd8);
        repeat (3) @(negedge clk);
        chk("oneshot_irq_held", {31'd0, bus.IRQ}, 32'd1);
        rd(2'd0, d);
        chk("oneshot_ctrl", d, 32'h8);
        rd(2'd2, d);
        chk("oneshot_count_end", d, 32'd0);
        wr(2'd0, 32'h0);
        chk("oneshot_irq_clear", {31'd0, bus.IRQ}, 32'd0);

        // auto-reload, PRESET=3
        do_reset;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        wait_irq(n);
        chk("reload_first", n, 32'd6);
        @(negedge clk);
        chk("reload_pulse_width", {31'd0, bus.IRQ}, 32'd0);
        @(negedge clk);
        rd(2'd2, d);
        chk("reload_count", d, 32'd3);
        wait_irq(n);
        chk("reload_gap", n + 2, 32'd6);
        wr(2'd0, 32'h0);

        // EN cleared mid-count freezes COUNT
        do_reset;
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        repeat (4) @(negedge clk);
        rd(2'd2, d);
        chk("freeze_before", d, 32'd8);
        wr(2'd0, 32'h8);
        irq_seen = 1'b0;
        idle_watch(10);
        rd(2'd2, d);
        chk("freeze_count", d, 32'd7);
        chk("freeze_no_irq", {31'd0, irq_seen}, 32'd0);

        // PRESET rewrite during CNT applies at the next reload
        do_reset;
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        repeat (3) @(negedge clk);
        wr(2'd1, 32'd9);
        rd(2'd2, d);
        chk("preset_mid_count", d, 32'd2);
        wait_irq(n);
        chk("preset_mid_first", n, 32'd3);
        repeat (2) @(negedge clk);
        rd(2'd2, d);
        chk("preset_mid_reload", d, 32'd9);
        wait_irq(n);
        chk("preset_mid_second", n, 32'd10);
        wr(2'd0, 32'h0);

        // PRESET=0 does not underflow
        do_reset;
        wr(2'd0, 32'h9);
        wait_irq(n);
        chk("zero_latency", n, 32'd3);
        repeat (3) @(negedge clk);
        rd(2'd2, d);
        chk("zero_no_wrap", d, 32'd0);

        // CTRL write in the same cycle as the one-shot EN clear
        do_reset;
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        wait_irq(n);
        chk("buswin_first", n, 32'd4);
        wr(2'd0, 32'h9);
        chk("buswin_flag_clr", {31'd0, bus.IRQ}, 32'd0);
        rd(2'd0, d);
        chk("buswin_ctrl", d, 32'h9);
        wait_irq(n);
        chk("buswin_restart", n, 32'd4);

        // masked one-shot, then unmasking write clears the flag
        do_reset;
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        irq_seen = 1'b0;
        idle_watch(10);
        rd(2'd0, d);
        chk("masked_done_ctrl", d, 32'h0);
        wr(2'd0, 32'h8);
        idle_watch(3);
        chk("masked_no_irq", {31'd0, irq_seen}, 32'd0);

        // asynchronous reset while COUNT=2
        do_reset;
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);
        repeat (6) @(negedge clk);
        rd(2'd2, d);
        chk("rst_mid_before", d, 32'd2);
        reset = 1'b0;
        rd(2'd2, d);
        chk("rst_mid_count", d, 32'd0);
        chk("rst_mid_irq", {31'd0, bus.IRQ}, 32'd0);
        rd(2'd0, d);
        chk("rst_mid_ctrl", d, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        irq_seen = 1'b0;
        idle_watch(10);
        rd(2'd2, d);
        chk("rst_mid_idle", d, 32'd0);
        chk("rst_mid_no_irq", {31'd0, irq_seen}, 32'd0);

`ifdef IRQ_TIMER_PRESCALE_EN
        // prescaled: PSC=1, PRESET=2
        do_reset;
        wr(2'd3, 32'd1);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        wait_irq(n);
        chk("psc_latency", n, 32'd8);
        rd(2'd3, d);
        chk("psc_readback", d, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
